sram_like_arbiter: RTL and testbench

- Shares one downstream SRAM-like port (req/addr_ok/data_ok) between two upstream requesters: instruction side (inst_*) and data side (data_*, typically the write-buffer output).
- Sits between the fetch/write-buffer front ends and the cache/AXI bridge.
- Arbitrates address phases and tracks in-flight transactions in order, so each downstream data_ok is routed back to the requester that issued it.

---
 rtl/sram_like_arbiter_if.sv | 22 ++
 rtl/sram_like_arbiter.sv | 100 ++++++++++
 tb/tb_sram_like_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_arbiter_if.sv
// rtl/sram_like_arbiter_if.sv - SRAM-like request/response port bundle
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        addr_ok;
    logic        data_ok;

    modport master (
        output req, wr, size, addr, wdata, wstrb,
        input  rdata, addr_ok, data_ok
    );

    modport slave (
        input  req, wr, size, addr, wdata, wstrb,
        output rdata, addr_ok, data_ok
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - two-requester SRAM-like port arbiter with in-order completion routing
module sram_like_arbiter #(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    sram_like_arbiter_if.slave           inst,
    sram_like_arbiter_if.slave           data,
    sram_like_arbiter_if.master          mem,
    output logic [$clog2(OUTSTANDING):0] inflight,
    output logic                         err_spurious
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;

    logic [OUTSTANDING-1:0] tag_q;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic                   lock_q;
    logic                   lock_src_q;
    logic [7:0]             starve_q;

    logic full;
    logic lock_src_req;
    logic lock_eff;
    logic grant_data;
    logic accept;
    logic pop;

    assign full         = (count == CW'(OUTSTANDING));
    assign lock_src_req = lock_src_q ? data.req : inst.req;
    // A lock whose owner has withdrawn must not steer the mux to an idle side.
    assign lock_eff     = lock_q & lock_src_req;

    always_comb begin
        grant_data = 1'b1;
        if (lock_eff)
            grant_data = lock_src_q;
        else if (inst.req && (!data.req || starve_q == 8'(STARVE_LIMIT)))
            grant_data = 1'b0;
    end

    assign mem.req   = (inst.req | data.req) & ~full;
    assign mem.wr    = grant_data ? data.wr    : inst.wr;
    assign mem.size  = grant_data ? data.size  : inst.size;
    assign mem.addr  = grant_data ? data.addr  : inst.addr;
    assign mem.wdata = grant_data ? data.wdata : inst.wdata;
    assign mem.wstrb = grant_data ? data.wstrb : inst.wstrb;

    assign accept       = mem.req & mem.addr_ok;
    assign inst.addr_ok = accept & ~grant_data;
    assign data.addr_ok = accept & grant_data;

    assign pop          = mem.data_ok & (count != '0);
    assign inst.data_ok = pop & ~tag_q[rd_ptr];
    assign data.data_ok = pop & tag_q[rd_ptr];
    assign inst.rdata   = mem.rdata;
    assign data.rdata   = mem.rdata;
    assign inflight     = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            lock_q       <= 1'b0;
            lock_src_q   <= 1'b0;
            starve_q     <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (accept) begin
                tag_q[wr_ptr] <= grant_data;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(accept) - CW'(pop);
            if (mem.data_ok && count == '0)
                err_spurious <= 1'b1;

            if (accept) begin
                lock_q <= 1'b0;
            end else if (mem.req) begin
                lock_q     <= 1'b1;
                lock_src_q <= grant_data;
            end else if (lock_q && !lock_src_req) begin
                lock_q <= 1'b0;
            end

            // Inst is promoted once it has lost STARVE_LIMIT arbitrations in a row.
            if (accept && !grant_data)
                starve_q <= '0;
            else if (accept && inst.req && starve_q != 8'(STARVE_LIMIT))
                starve_q <= starve_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - self-checking bench for sram_like_arbiter
module tb_sram_like_arbiter;
    localparam int OUT = 4;
    localparam int LIM = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] inflight;
    logic       err_spurious;
    int         checks = 0;
    int         errors = 0;

    sram_like_arbiter_if inst_if ();
    sram_like_arbiter_if data_if ();
    sram_like_arbiter_if mem_if ();

    sram_like_arbiter #(.OUTSTANDING(OUT), .STARVE_LIMIT(LIM)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst         (inst_if),
        .data         (data_if),
        .mem          (mem_if),
        .inflight     (inflight),
        .err_spurious (err_spurious)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_if.req = 0; inst_if.wr = 0; inst_if.size = 2'd2; inst_if.addr = 0;
        inst_if.wdata = 0; inst_if.wstrb = 0;
        data_if.req = 0; data_if.wr = 0; data_if.size = 2'd2; data_if.addr = 0;
        data_if.wdata = 0; data_if.wstrb = 0;
        mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = 0;
    endtask

    task automatic do_reset();
        tick();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        #1;
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d want 0", inflight); end
        checks++; if (err_spurious !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err_spurious); end
        checks++; if (mem_if.req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_if.req); end
    endtask

    task automatic test_single_read();
        do_reset();
        tick();
        inst_if.req = 1; inst_if.addr = 32'hBFC0_0000; mem_if.addr_ok = 1;
        #1;
        checks++; if (mem_if.addr !== 32'hBFC0_0000) begin errors++; $display("FAIL single_addr got %h want bfc00000", mem_if.addr); end
        checks++; if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b10) begin errors++; $display("FAIL single_addr_ok got %b want 10", {inst_if.addr_ok, data_if.addr_ok}); end
        tick();
        idle();
        #1;
        checks++; if (inflight !== 3'd1 || inst_if.addr_ok !== 1'b0) begin errors++; $display("FAIL single_mid got inflight=%0d aok=%b want 1,0", inflight, inst_if.addr_ok); end
        tick();
        mem_if.data_ok = 1; mem_if.rdata = 32'h3C1D_A000;
        #1;
        checks++; if ({inst_if.data_ok, data_if.data_ok} !== 2'b10 || inst_if.rdata !== 32'h3C1D_A000) begin
            errors++; $display("FAIL single_data_ok got %b rdata=%h want 10 3c1da000", {inst_if.data_ok, data_if.data_ok}, inst_if.rdata); end
        tick();
        idle();
        #1;
        checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL single_end_inflight got %0d want 0", inflight); end
    endtask

    task automatic test_starvation();
        bit prev_data = 0;
        do_reset();
        for (int i = 0; i < 27; i++) begin
            bit exp_data;
            tick();
            inst_if.req = 1; inst_if.addr = 32'h1000_0000 + i;
            data_if.req = 1; data_if.addr = 32'h2000_0000 + i;
            mem_if.addr_ok = 1; mem_if.data_ok = (i > 0); mem_if.rdata = i;
            #1;
            exp_data = (i % (LIM + 1)) != LIM;
            checks++; if (data_if.addr_ok !== exp_data || inst_if.addr_ok !== !exp_data) begin
                errors++; $display("FAIL starve_grant[%0d] got i=%b d=%b want d=%b", i, inst_if.addr_ok, data_if.addr_ok, exp_data); end
            checks++; if (mem_if.addr !== (exp_data ? 32'h2000_0000 + i : 32'h1000_0000 + i)) begin
                errors++; $display("FAIL starve_addr[%0d] got %h", i, mem_if.addr); end
            if (i > 0) begin
                checks++; if (data_if.data_ok !== prev_data || inst_if.data_ok !== !prev_data) begin
                    errors++; $display("FAIL starve_route[%0d] got i=%b d=%b want d=%b", i, inst_if.data_ok, data_if.data_ok, prev_data); end
            end
            prev_data = exp_data;
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < OUT; i++) begin
            tick();
            data_if.req = 1; data_if.addr = $urandom; mem_if.addr_ok = 1;
            #1;
            checks++; if (data_if.addr_ok !== 1'b1) begin errors++; $display("FAIL fill_accept[%0d] got %b want 1", i, data_if.addr_ok); end
        end
        tick();
        #1;
        checks++; if (inflight !== 3'd4 || mem_if.req !== 1'b0 || data_if.addr_ok !== 1'b0) begin
            errors++; $display("FAIL fill_full got inflight=%0d req=%b aok=%b want 4,0,0", inflight, mem_if.req, data_if.addr_ok); end
        mem_if.data_ok = 1;
        #1;
        checks++; if (data_if.data_ok !== 1'b1) begin errors++; $display("FAIL fill_pop got %b want 1", data_if.data_ok); end
        tick();
        mem_if.data_ok = 0;
        #1;
        checks++; if (inflight !== 3'd3 || mem_if.req !== 1'b1 || data_if.addr_ok !== 1'b1) begin
            errors++; $display("FAIL fill_reopen got inflight=%0d req=%b aok=%b want 3,1,1", inflight, mem_if.req, data_if.addr_ok); end
    endtask

    task automatic test_ordering();
        do_reset();
        tick(); data_if.req = 1; data_if.addr = 32'hA0; mem_if.addr_ok = 1;
        tick(); data_if.req = 0; inst_if.req = 1; inst_if.addr = 32'hB0;
        tick(); inst_if.req = 0; data_if.req = 1; data_if.addr = 32'hA4;
        tick(); idle();
        for (int i = 1; i <= 3; i++) begin
            bit [1:0] exp_route;
            exp_route = (i == 2) ? 2'b10 : 2'b01;
            mem_if.data_ok = 1; mem_if.rdata = i;
            #1;
            checks++; if ({inst_if.data_ok, data_if.data_ok} !== exp_route || data_if.rdata !== 32'(i)) begin
                errors++; $display("FAIL order[%0d] got %b rdata=%0d want %b %0d", i, {inst_if.data_ok, data_if.data_ok}, data_if.rdata, exp_route, i); end
            tick();
        end
        idle();
    endtask

    task automatic test_lock();
        do_reset();
        tick();
        inst_if.req = 1; inst_if.addr = 32'h0000_1110;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin data_if.req = 1; data_if.addr = 32'h0000_2220; end
            mem_if.addr_ok = (c == 3);
            #1;
            checks++; if (mem_if.addr !== 32'h0000_1110 || data_if.addr_ok !== 1'b0 || inst_if.addr_ok !== (c == 3)) begin
                errors++; $display("FAIL lock_hold[%0d] got addr=%h iaok=%b daok=%b", c, mem_if.addr, inst_if.addr_ok, data_if.addr_ok); end
            tick();
        end
        inst_if.req = 0;
        #1;
        checks++; if (mem_if.addr !== 32'h0000_2220 || data_if.addr_ok !== 1'b1) begin
            errors++; $display("FAIL lock_after got addr=%h daok=%b want 00002220 1", mem_if.addr, data_if.addr_ok); end
        tick();
        idle();
    endtask

    task automatic test_spurious_reset();
        do_reset();
        tick();
        mem_if.data_ok = 1;
        #1;
        checks++; if (inst_if.data_ok !== 1'b0 || data_if.data_ok !== 1'b0) begin errors++; $display("FAIL spur_route got %b%b want 00", inst_if.data_ok, data_if.data_ok); end
        tick();
        mem_if.data_ok = 0;
        #1;
        checks++; if (err_spurious !== 1'b1) begin errors++; $display("FAIL spur_err got %b want 1", err_spurious); end
        data_if.req = 1; mem_if.addr_ok = 1;
        tick(); tick();
        data_if.req = 0; inst_if.req = 1; mem_if.addr_ok = 0;
        tick();
        #1;
        checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL spur_pre got %0d want 2", inflight); end
        rst = 1;
        tick();
        rst = 0;
        inst_if.req = 1; inst_if.addr = 32'h11; data_if.req = 1; data_if.addr = 32'h22;
        #1;
        checks++; if (inflight !== 3'd0 || err_spurious !== 1'b0) begin errors++; $display("FAIL rst_state got inflight=%0d err=%b want 0 0", inflight, err_spurious); end
        checks++; if (mem_if.addr !== 32'h22) begin errors++; $display("FAIL rst_lock got addr=%h want 22", mem_if.addr); end
        tick();
        idle();
    endtask

    task automatic test_random();
        int  q[$];
        int  held = -1;
        int  starve = 0;
        bit  err_m = 0;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit ireq, dreq, aok, dok, exp_req, acc, full, popm, held_req;
            int owner, head;
            tick();
            ireq = ($urandom % 3) != 0; dreq = ($urandom % 3) != 0;
            aok = ($urandom % 2) != 0; dok = ($urandom % 10) < 4;
            inst_if.req = ireq; inst_if.addr = $urandom; inst_if.wdata = $urandom; inst_if.wr = $urandom;
            data_if.req = dreq; data_if.addr = $urandom; data_if.wdata = $urandom; data_if.wr = $urandom;
            mem_if.addr_ok = aok; mem_if.data_ok = dok; mem_if.rdata = $urandom;
            #1;
            full = (q.size() == OUT);
            exp_req = (ireq || dreq) && !full;
            held_req = (held == 1) ? dreq : (held == 0) ? ireq : 1'b0;
            if (held_req) owner = held;
            else if (ireq && dreq) owner = (starve >= LIM) ? 0 : 1;
            else if (ireq) owner = 0;
            else owner = 1;
            acc = exp_req && aok;
            popm = dok && q.size() > 0;
            head = (q.size() > 0) ? q[0] : 0;

            checks++; if (mem_if.req !== exp_req) begin errors++; $display("FAIL rnd_req[%0d] got %b want %b", n, mem_if.req, exp_req); end
            if (exp_req) begin
                checks++; if (mem_if.addr !== (owner == 1 ? data_if.addr : inst_if.addr) ||
                              mem_if.wdata !== (owner == 1 ? data_if.wdata : inst_if.wdata)) begin
                    errors++; $display("FAIL rnd_mux[%0d] got %h want owner %0d", n, mem_if.addr, owner); end
            end
            checks++; if (inst_if.addr_ok !== (acc && owner == 0) || data_if.addr_ok !== (acc && owner == 1)) begin
                errors++; $display("FAIL rnd_aok[%0d] got %b%b owner %0d acc %b", n, inst_if.addr_ok, data_if.addr_ok, owner, acc); end
            checks++; if (inst_if.data_ok !== (popm && head == 0) || data_if.data_ok !== (popm && head == 1)) begin
                errors++; $display("FAIL rnd_dok[%0d] got %b%b want pop %b head %0d", n, inst_if.data_ok, data_if.data_ok, popm, head); end
            checks++; if (inflight !== 3'(q.size()) || err_spurious !== err_m) begin
                errors++; $display("FAIL rnd_state[%0d] got inflight=%0d err=%b want %0d %b", n, inflight, err_spurious, q.size(), err_m); end
            checks++; if (inst_if.rdata !== mem_if.rdata || data_if.rdata !== mem_if.rdata) begin
                errors++; $display("FAIL rnd_rdata[%0d] got %h/%h", n, inst_if.rdata, data_if.rdata); end

            if (popm) void'(q.pop_front());
            else if (dok) err_m = 1;
            if (acc) q.push_back(owner);
            if (acc) held = -1;
            else if (exp_req) held = owner;
            else if (held >= 0 && !held_req) held = -1;
            if (acc && owner == 0) starve = 0;
            else if (acc && ireq && starve < LIM) starve++;
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_single_read();
        test_starvation();
        test_fill();
        test_ordering();
        test_lock();
        test_spurious_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
